// File: rtl/md_unit_param_if.sv
// md_unit_param_if: operation, operand and status bundle for the multiply/divide unit
interface md_unit_param_if #(parameter int WIDTH = 32);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic             flush;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   modport master (output start, op, src1, src2, flush, input out, busy, done);
   modport slave (input start, op, src1, src2, flush, output out, busy, done);
endinterface

// File: rtl/md_unit_param.sv
// md_unit_param: multi-cycle multiply/divide unit with HI/LO registers and flush abort
module md_unit_param #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input logic            clk,
   input logic            reset,
   md_unit_param_if.slave bus
);
   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   logic [WIDTH-1:0]   hi, lo;
   logic               busy, done, is_div_r;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] snap;
   logic               sgn, is_div, valid, s1, s2;
   logic [2*WIDTH-1:0] ma, mb, prod, hl, res;
   logic [WIDTH-1:0]   a_abs, b_abs, q_abs, r_abs, q_s, r_s;
   assign bus.out  = (bus.op == 4'd6) ? hi : (bus.op == 4'd7) ? lo : '0;
   assign bus.busy = busy;
   assign bus.done = done;
   // result of the op presented this cycle; the result is frozen into snap at accept time
   always_comb begin
      sgn    = ~bus.op[0];
      is_div = bus.op[3:1] == 3'b001;
      valid  = ~bus.op[2];
      s1     = bus.src1[WIDTH-1];
      s2     = bus.src2[WIDTH-1];
      hl     = {hi, lo};
      ma     = {{WIDTH{sgn & s1}}, bus.src1};
      mb     = {{WIDTH{sgn & s2}}, bus.src2};
      prod   = ma * mb;
      a_abs  = s1 ? -bus.src1 : bus.src1;
      b_abs  = s2 ? -bus.src2 : bus.src2;
      q_abs  = (b_abs == '0) ? '0 : a_abs / b_abs;
      r_abs  = (b_abs == '0) ? '0 : a_abs % b_abs;
      q_s    = (s1 ^ s2) ? -q_abs : q_abs;
      r_s    = s1 ? -r_abs : r_abs;
      res    = (is_div && bus.src2 == '0) ? hl :
               (bus.op == 4'd2) ? {r_s, q_s} :
               (bus.op == 4'd3) ? {bus.src1 % bus.src2, bus.src1 / bus.src2} :
               bus.op[3] ? (bus.op[1] ? hl - prod : hl + prod) : prod;
   end
   // accept, count down the latency, commit or abort, and handle MTHI/MTLO
   always_ff @(posedge clk) begin
      if (reset) begin
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         snap     <= '0;
         is_div_r <= 1'b0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (bus.flush) begin
               busy <= 1'b0;
               cnt  <= '0;
            end else if (cnt == (is_div_r ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1))) begin
               {hi, lo} <= snap;
               busy     <= 1'b0;
               done     <= 1'b1;
               cnt      <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else if (!bus.flush) begin
            if (bus.start && valid) begin
               snap     <= res;
               busy     <= 1'b1;
               cnt      <= '0;
               is_div_r <= is_div;
            end else if (bus.op == 4'd4) begin
               hi <= bus.src1;
            end else if (bus.op == 4'd5) begin
               lo <= bus.src1;
            end
         end
      end
   end
endmodule

// File: tb/tb_md_unit_param.sv
// tb_md_unit_param: directed and randomized checks of md_unit_param against a behavioural model
module tb_md_unit_param;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic chk_en = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   n;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_pend = '0;
   int          m_left = 0;
   logic        m_done = 1'b0;

   md_unit_param_if #(.WIDTH(32)) bus();
   md_unit_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
      end
   endtask

   function automatic logic [63:0] calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] hl);
      longint      sp = longint'(int'(a)) * longint'(int'(b));
      logic [63:0] up = 64'(a) * 64'(b);
      case (o)
         4'd0: return sp;
         4'd1: return up;
         4'd8: return hl + sp;
         4'd9: return hl + up;
         4'd10: return hl - sp;
         4'd11: return hl - up;
         4'd2: begin
            if (b == 0) return hl;
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {32'h0, 32'h8000_0000};
            return {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
         end
         4'd3: return (b == 0) ? hl : {a % b, a / b};
         default: return hl;
      endcase
   endfunction

   // behavioural model: remaining-cycle count plus pending result, committed when the count runs out
   always @(posedge clk) begin
      if (reset) begin
         m_hi <= '0;
         m_lo <= '0;
         m_left <= 0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            if (bus.flush) m_left <= 0;
            else begin
               m_left <= m_left - 1;
               if (m_left == 1) begin
                  {m_hi, m_lo} <= m_pend;
                  m_done <= 1'b1;
               end
            end
         end else if (!bus.flush) begin
            if (bus.start && (bus.op < 4 || (bus.op >= 8 && bus.op < 12))) begin
               m_pend <= calc(bus.op, bus.src1, bus.src2, {m_hi, m_lo});
               m_left <= (bus.op == 2 || bus.op == 3) ? 10 : 5;
            end else if (bus.op == 4) m_hi <= bus.src1;
            else if (bus.op == 5) m_lo <= bus.src1;
         end
      end
   end

   // every-cycle comparison of the DUT outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'b0, bus.busy}, {31'b0, m_left > 0});
         check("done", {31'b0, bus.done}, {31'b0, m_done});
         check("out", bus.out, (bus.op == 6) ? m_hi : (bus.op == 7) ? m_lo : 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic f);
      bus.start = s;
      bus.op = o;
      bus.src1 = a;
      bus.src2 = b;
      bus.flush = f;
   endtask

   task automatic peek(input string nm, input logic [3:0] o, input logic [31:0] want);
      bus.op = o;
      #1;
      check(nm, bus.out, want);
      bus.op = 4'd15;
   endtask

   task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int cyc);
      drive(1'b1, o, a, b, 1'b0);
      step();
      drive(1'b0, 4'd15, '0, '0, 1'b0);
      cyc = 0;
      while (bus.busy && cyc < 100) begin
         cyc++;
         step();
      end
   endtask

   function automatic logic [31:0] rv();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hffff_ffff;
         2: return 32'h8000_0000;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      drive(1'b0, 4'd15, '0, '0, 1'b0);
      step();
      step();
      reset = 1'b0;
      chk_en = 1'b1;
      check("rst_busy", {31'b0, bus.busy}, 32'h0);
      check("rst_done", {31'b0, bus.done}, 32'h0);
      peek("rst_hi", 4'd6, 32'h0);
      peek("rst_lo", 4'd7, 32'h0);
      run(4'd0, 32'hffff_fffd, 32'd7, n);
      check("mult_lat", n, 32'd5);
      check("mult_done", {31'b0, bus.done}, 32'h1);
      peek("mult_hi", 4'd6, 32'hffff_ffff);
      peek("mult_lo", 4'd7, 32'hffff_ffeb);
      step();
      check("done_pulse", {31'b0, bus.done}, 32'h0);
      run(4'd3, 32'd100, 32'd7, n);
      check("divu_lat", n, 32'd10);
      peek("divu_hi", 4'd6, 32'd2);
      peek("divu_lo", 4'd7, 32'd14);
      run(4'd2, 32'hffff_fff9, 32'd2, n);
      peek("div_hi", 4'd6, 32'hffff_ffff);
      peek("div_lo", 4'd7, 32'hffff_fffd);
      drive(1'b0, 4'd4, 32'd5, '0, 1'b0);
      step();
      drive(1'b0, 4'd5, 32'd1, '0, 1'b0);
      step();
      run(4'd2, 32'd1234, 32'd0, n);
      check("div0_lat", n, 32'd10);
      peek("div0_hi", 4'd6, 32'd5);
      peek("div0_lo", 4'd7, 32'd1);
      run(4'd2, 32'h8000_0000, 32'hffff_ffff, n);
      peek("divmin_hi", 4'd6, 32'h0);
      peek("divmin_lo", 4'd7, 32'h8000_0000);
      drive(1'b0, 4'd4, 32'd0, '0, 1'b0);
      step();
      drive(1'b0, 4'd5, 32'd10, '0, 1'b0);
      step();
      run(4'd9, 32'd3, 32'd4, n);
      peek("maddu_hi", 4'd6, 32'h0);
      peek("maddu_lo", 4'd7, 32'd22);
      run(4'd10, 32'd1, 32'd23, n);
      peek("msub_hi", 4'd6, 32'hffff_ffff);
      peek("msub_lo", 4'd7, 32'hffff_ffff);
      drive(1'b1, 4'd0, 32'd2, 32'd3, 1'b0);
      step();
      drive(1'b0, 4'd15, '0, '0, 1'b0);
      step();
      step();
      drive(1'b1, 4'd0, 32'd2, 32'd3, 1'b1);
      step();
      check("flush_busy", {31'b0, bus.busy}, 32'h0);
      drive(1'b0, 4'd15, '0, '0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check("flush_nodone", {31'b0, bus.done | bus.busy}, 32'h0);
         step();
      end
      peek("flush_hi", 4'd6, 32'hffff_ffff);
      peek("flush_lo", 4'd7, 32'hffff_ffff);
      drive(1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
      step();
      drive(1'b1, 4'd1, 32'd2, 32'd2, 1'b0);
      step();
      drive(1'b0, 4'd15, '0, '0, 1'b0);
      peek("mflo_busy", 4'd7, 32'hffff_ffff);
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         step();
      end
      check("ign_lat", n, 32'd4);
      peek("ign_hi", 4'd6, 32'h0);
      peek("ign_lo", 4'd7, 32'd81);
      drive(1'b1, 4'd0, 32'd5, 32'd5, 1'b0);
      step();
      drive(1'b0, 4'd15, '0, '0, 1'b0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2_busy", {31'b0, bus.busy}, 32'h0);
      check("rst2_done", {31'b0, bus.done}, 32'h0);
      peek("rst2_hi", 4'd6, 32'h0);
      peek("rst2_lo", 4'd7, 32'h0);
      repeat (3000) begin
         reset = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), rv(), rv(), $urandom_range(0, 19) == 0);
         step();
      end
      reset = 1'b0;
      drive(1'b0, 4'd15, '0, '0, 1'b0);
      repeat (15) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
